a0_uart_tx: RTL

Downstream consumer of the CPU top-level a0 result port. Detects every change of a0, queues changed values in a small FIFO, and serialises each 32-bit word onto a single UART TX line (8N1, LSB byte first). This lets test programs stream results off-chip without stalling the core.

---
 rtl/a0_uart_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/a0_uart_tx.sv
// a0_uart_tx: queues every change of the CPU a0 register and streams each word out as 8N1 UART bytes, LSB byte first.
// Optional feature macro A0_TX_FRAME_EN: each word is preceded by a 0xA5 sync byte (five bytes per word).
module a0_uart_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DATA_WIDTH-1:0]       a0,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam int BAUD_LAST_I = CLKS_PER_BIT - 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_LAST_I[BAUD_W-1:0];
    localparam logic [AW:0]       FULL_CNT  = FIFO_DEPTH[AW:0];
`ifdef A0_TX_FRAME_EN
    localparam int          SHIFT_W   = DATA_WIDTH + 8;
    localparam logic [2:0]  LAST_BYTE = 3'd4;
`else
    localparam int          SHIFT_W   = DATA_WIDTH;
    localparam logic [2:0]  LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [2:0]          byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [DATA_WIDTH-1:0] last_a0_q;
    logic                overflow_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q, count;
    logic                empty, full, push_req, push, pop, baud_done;
    logic [SHIFT_W-1:0]  load_word;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign push_req  = en && (a0 != last_a0_q);
    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    assign push      = push_req && (!full || pop);
    assign baud_done = (baud_q == BAUD_LAST);

`ifdef A0_TX_FRAME_EN
    assign load_word = {mem_q[rd_ptr_q[AW-1:0]], 8'hA5};
`else
    assign load_word = mem_q[rd_ptr_q[AW-1:0]];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_a0_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (en) last_a0_q <= a0;
            if (push_req && !push) overflow_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= a0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_d    = load_word;
                    byte_idx_d = '0;
                    baud_d     = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        shift_d    = load_word;
                        byte_idx_d = '0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decided from the next state so tx leaves a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign overflow   = overflow_q;
    assign fifo_count = count;

endmodule
